// File: rtl/writeback_unit.sv
// Writeback arbiter: merges fixed-latency ALU results with a queue of
// long-latency results onto one register-file write port, and keeps a
// per-register scoreboard of outstanding long-latency destinations.
module writeback_unit #(
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        lat_valid,
  output logic        lat_ready,
  input  logic [4:0]  lat_reg,
  input  logic [31:0] lat_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  output logic        write_enable,
  output logic [4:0]  write_register,
  output logic [31:0] busW,
  output logic [31:0] busy
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t         fifo_q [QDEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  logic            lat_acc, fifo_empty, drain, bypass, enq;
  logic            sel_vld, sel_lat, wr_ok;
  logic [4:0]      sel_reg;
  logic [31:0]     sel_data;
  logic [31:0]     busy_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on the registered occupancy.
  assign lat_ready  = (count < CW'(QDEPTH));
  assign lat_acc    = lat_valid && lat_ready;
  assign fifo_empty = (count == '0);
  assign drain      = !alu_valid && !fifo_empty;
  assign bypass     = !alu_valid && fifo_empty && lat_acc;
  assign enq        = lat_acc && !bypass;

  // Pick next write: ALU first, then FIFO head, then a bypassed result.
  always_comb begin
    sel_vld  = 1'b0;
    sel_lat  = 1'b0;
    sel_reg  = '0;
    sel_data = '0;
    if (alu_valid) begin
      sel_vld  = 1'b1;
      sel_reg  = alu_reg;
      sel_data = alu_data;
    end else if (drain) begin
      sel_vld  = 1'b1;
      sel_lat  = 1'b1;
      sel_reg  = fifo_q[rd_ptr].rd;
      sel_data = fifo_q[rd_ptr].data;
    end else if (bypass) begin
      sel_vld  = 1'b1;
      sel_lat  = 1'b1;
      sel_reg  = lat_reg;
      sel_data = lat_data;
    end
  end

  // r0 writes are swallowed: the result is consumed but nothing is written.
  assign wr_ok = sel_vld && (sel_reg != 5'd0);

  // Scoreboard update: clear lands with the write, a coincident issue wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok && sel_lat)
      busy_nxt[sel_reg] = 1'b0;
    if (issue_valid && (issue_reg != 5'd0))
      busy_nxt[issue_reg] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Write port, scoreboard and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_enable   <= 1'b0;
      write_register <= '0;
      busW           <= '0;
      busy           <= '0;
      count          <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
    end else begin
      write_enable   <= wr_ok;
      write_register <= wr_ok ? sel_reg  : 5'd0;
      busW           <= wr_ok ? sel_data : 32'd0;
      busy           <= busy_nxt;
      if (enq)
        wr_ptr <= ptr_inc(wr_ptr);
      if (drain)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (enq)
      fifo_q[wr_ptr] <= '{rd: lat_reg, data: lat_data};
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: vector table plus hand-written
// sequences for queue contention, scoreboard and mid-operation reset.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        lat_valid;
  logic        lat_ready;
  logic [4:0]  lat_reg;
  logic [31:0] lat_data;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic        write_enable;
  logic [4:0]  write_register;
  logic [31:0] busW;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  writeback_unit #(.QDEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .lat_valid(lat_valid), .lat_ready(lat_ready), .lat_reg(lat_reg), .lat_data(lat_data),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .write_enable(write_enable), .write_register(write_register), .busW(busW),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lr;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ir;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        rdy;
    logic [31:0] bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, logic av, logic [4:0] ar, logic [31:0] ad,
                              logic lv, logic [4:0] lr, logic [31:0] ld,
                              logic iv, logic [4:0] ir,
                              logic we, logic [4:0] wr, logic [31:0] wd,
                              logic rdy, logic [31:0] bsy);
    vec_t v;
    v.name = n; v.av = av; v.ar = ar; v.ad = ad; v.lv = lv; v.lr = lr; v.ld = ld;
    v.iv = iv; v.ir = ir; v.we = we; v.wr = wr; v.wd = wd; v.rdy = rdy; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then compare the post-edge outputs.
  task automatic step(input string nm, input logic r, input vec_t v);
    rst = r;
    alu_valid = v.av; alu_reg = v.ar; alu_data = v.ad;
    lat_valid = v.lv; lat_reg = v.lr; lat_data = v.ld;
    issue_valid = v.iv; issue_reg = v.ir;
    @(posedge clk);
    #1;
    chk({nm, ".we"},   {31'd0, write_enable}, {31'd0, v.we});
    chk({nm, ".reg"},  {27'd0, write_register}, {27'd0, v.wr});
    chk({nm, ".data"}, busW, v.wd);
    chk({nm, ".rdy"},  {31'd0, lat_ready}, {31'd0, v.rdy});
    chk({nm, ".busy"}, busy, v.bsy);
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_reg = 0; alu_data = 0;
    lat_valid = 0; lat_reg = 0; lat_data = 0;
    issue_valid = 0; issue_reg = 0;

    // Reset ignores all request inputs.
    step("reset0", 1'b1, mk("", 1, 5'd5, 32'h1, 1, 5'd6, 32'h2, 1, 5'd7, 0, 0, 0, 1, 0));
    step("reset1", 1'b1, mk("", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    //             name        av ar     ad            lv lr     ld            iv ir      we wr     wd            rdy busy
    tbl.push_back(mk("alu_r5",  1, 5'd5,  32'h12345678, 0, 0,     0,            0, 0,      1, 5'd5,  32'h12345678, 1, 0));
    tbl.push_back(mk("idle0",   0, 0,     0,            0, 0,     0,            0, 0,      0, 0,     0,            1, 0));
    tbl.push_back(mk("bypass3", 0, 0,     0,            1, 5'd3,  32'hA5A5A5A5, 0, 0,      1, 5'd3,  32'hA5A5A5A5, 1, 0));
    tbl.push_back(mk("byp_nost",0, 0,     0,            0, 0,     0,            0, 0,      0, 0,     0,            1, 0));
    tbl.push_back(mk("alu_r0",  1, 5'd0,  32'hFFFFFFFF, 0, 0,     0,            0, 0,      0, 0,     0,            1, 0));
    tbl.push_back(mk("lat_r0",  0, 0,     0,            1, 5'd0,  32'hFFFFFFFF, 0, 0,      0, 0,     0,            1, 0));
    tbl.push_back(mk("iss_r0",  0, 0,     0,            0, 0,     0,            1, 5'd0,   0, 0,     0,            1, 0));
    tbl.push_back(mk("iss_r12", 0, 0,     0,            0, 0,     0,            1, 5'd12,  0, 0,     0,            1, 32'h1000));
    tbl.push_back(mk("alu_r12", 1, 5'd12, 32'h1,        0, 0,     0,            0, 0,      1, 5'd12, 32'h1,        1, 32'h1000));
    tbl.push_back(mk("clr_r12", 0, 0,     0,            1, 5'd12, 32'hCAFE,     0, 0,      1, 5'd12, 32'hCAFE,     1, 0));
    tbl.push_back(mk("reiss12", 0, 0,     0,            0, 0,     0,            1, 5'd12,  0, 0,     0,            1, 32'h1000));
    tbl.push_back(mk("setwin",  0, 0,     0,            1, 5'd12, 32'hBEEF,     1, 5'd12,  1, 5'd12, 32'hBEEF,     1, 32'h1000));
    tbl.push_back(mk("clr2_12", 0, 0,     0,            1, 5'd12, 32'h1111,     0, 0,      1, 5'd12, 32'h1111,     1, 0));
    tbl.push_back(mk("enq20",   1, 5'd7,  32'h7,        1, 5'd20, 32'h20,       0, 0,      1, 5'd7,  32'h7,        1, 0));
    tbl.push_back(mk("enq21",   1, 5'd1,  32'h1,        1, 5'd21, 32'h21,       0, 0,      1, 5'd1,  32'h1,        0, 0));
    tbl.push_back(mk("full22",  1, 5'd2,  32'h2,        1, 5'd22, 32'h22,       0, 0,      1, 5'd2,  32'h2,        0, 0));
    tbl.push_back(mk("drain20", 0, 0,     0,            0, 0,     0,            0, 0,      1, 5'd20, 32'h20,       1, 0));
    tbl.push_back(mk("enqdeq",  0, 0,     0,            1, 5'd23, 32'h23,       0, 0,      1, 5'd21, 32'h21,       1, 0));
    tbl.push_back(mk("drain23", 0, 0,     0,            0, 0,     0,            0, 0,      1, 5'd23, 32'h23,       1, 0));
    tbl.push_back(mk("empty",   0, 0,     0,            0, 0,     0,            0, 0,      0, 0,     0,            1, 0));
    tbl.push_back(mk("enq_r0",  1, 5'd4,  32'h4,        1, 5'd0,  32'hFFFFFFFF, 0, 0,      1, 5'd4,  32'h4,        1, 0));
    tbl.push_back(mk("enq_r9",  1, 5'd6,  32'h6,        1, 5'd9,  32'h99,       0, 0,      1, 5'd6,  32'h6,        0, 0));
    tbl.push_back(mk("drn_r0",  0, 0,     0,            0, 0,     0,            0, 0,      0, 0,     0,            1, 0));
    tbl.push_back(mk("drn_r9",  0, 0,     0,            0, 0,     0,            0, 0,      1, 5'd9,  32'h99,       1, 0));
    tbl.push_back(mk("idle1",   0, 0,     0,            0, 0,     0,            0, 0,      0, 0,     0,            1, 0));

    foreach (tbl[i]) step(tbl[i].name, 1'b0, tbl[i]);

    // Contention: ALU held four cycles while r8 then r9 queue up.
    step("c_iss8",  0, mk("", 0, 0,    0,   0, 0,     0,     1, 5'd8, 0, 0,    0,     1, 32'h100));
    step("c_iss9",  0, mk("", 0, 0,    0,   0, 0,     0,     1, 5'd9, 0, 0,    0,     1, 32'h300));
    step("c_alu1",  0, mk("", 1, 5'd1, 1,   1, 5'd8,  32'h88,0, 0,    1, 5'd1, 1,     1, 32'h300));
    step("c_alu2",  0, mk("", 1, 5'd1, 2,   1, 5'd9,  32'h99,0, 0,    1, 5'd1, 2,     0, 32'h300));
    step("c_alu3",  0, mk("", 1, 5'd1, 3,   1, 5'd10, 32'hAA,0, 0,    1, 5'd1, 3,     0, 32'h300));
    step("c_alu4",  0, mk("", 1, 5'd1, 4,   0, 0,     0,     0, 0,    1, 5'd1, 4,     0, 32'h300));
    step("c_wr8",   0, mk("", 0, 0,    0,   0, 0,     0,     0, 0,    1, 5'd8, 32'h88,1, 32'h200));
    step("c_wr9",   0, mk("", 0, 0,    0,   0, 0,     0,     0, 0,    1, 5'd9, 32'h99,1, 0));
    step("c_idle",  0, mk("", 0, 0,    0,   0, 0,     0,     0, 0,    0, 0,    0,     1, 0));

    // Reset with a full queue and live scoreboard bits.
    step("r_iss8",  0, mk("", 0, 0,    0,   0, 0,     0,     1, 5'd8, 0, 0,    0,     1, 32'h100));
    step("r_iss9",  0, mk("", 0, 0,    0,   0, 0,     0,     1, 5'd9, 0, 0,    0,     1, 32'h300));
    step("r_fill8", 0, mk("", 1, 5'd2, 5,   1, 5'd8,  32'h88,0, 0,    1, 5'd2, 5,     1, 32'h300));
    step("r_fill9", 0, mk("", 1, 5'd2, 6,   1, 5'd9,  32'h99,0, 0,    1, 5'd2, 6,     0, 32'h300));
    step("r_rst",   1, mk("", 1, 5'd3, 7,   1, 5'd4,  32'h44,1, 5'd5, 0, 0,    0,     1, 0));
    step("r_post1", 0, mk("", 0, 0,    0,   0, 0,     0,     0, 0,    0, 0,    0,     1, 0));
    step("r_post2", 0, mk("", 0, 0,    0,   0, 0,     0,     0, 0,    0, 0,    0,     1, 0));
    step("r_byp",   0, mk("", 0, 0,    0,   1, 5'd3,  32'h3, 0, 0,    1, 5'd3, 32'h3, 1, 0));
    step("r_idle",  0, mk("", 0, 0,    0,   0, 0,     0,     0, 0,    0, 0,    0,     1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
